// File: rtl/slurm16_data_memory_responder.sv
// slurm16_data_memory_responder
//   Responder end of the SLURM16 CPU data-memory bus. It accepts one byte-masked
//   16-bit read or write at a time, waits a fixed number of cycles, then reports
//   completion with a one-cycle success pulse.
//
// Ports
//   CLK           system clock
//   RST           asynchronous, active-high reset (RAM contents are kept)
//   mem_address   byte address; word index = mem_address[DEPTH_BITS:1]
//   mem_data_in   write data
//   mem_rd        read request, held by the requester until success
//   mem_wr        write request, held by the requester until success (wins over mem_rd)
//   mem_wr_mask   byte enables: bit0 -> [7:0], bit1 -> [15:8]
//   mem_data_out  data of the last completed read
//   mem_success   high for exactly one cycle when a transaction completes
//   busy          high while a transaction is in flight (BUSY or DONE)
//
// LATENCY is the number of cycles from acceptance to the success cycle and must
// lie in 1..15 (the wait counter is 4 bits wide).
module slurm16_data_memory_responder #(
  parameter int ADDRESS_BITS = 16,
  parameter int BITS         = 16,
  parameter int DEPTH_BITS   = 12,
  parameter int LATENCY      = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ADDRESS_BITS-1:0] mem_address,
  input  logic [BITS-1:0]         mem_data_in,
  input  logic                    mem_rd,
  input  logic                    mem_wr,
  input  logic [1:0]              mem_wr_mask,
  output logic [BITS-1:0]         mem_data_out,
  output logic                    mem_success,
  output logic                    busy
);

  localparam int         LANE_BITS  = BITS / 2;
  localparam int         DEPTH      = 1 << DEPTH_BITS;
  localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              count_reg, count_next;
  logic [DEPTH_BITS-1:0]   word_reg;
  logic [BITS-1:0]         data_reg;
  logic [1:0]              mask_reg;
  logic                    write_reg;
  logic                    data_valid_reg;

  logic                    request;
  logic                    enter_done;
  logic [DEPTH_BITS-1:0]   req_word;
  logic [DEPTH_BITS-1:0]   op_word;
  logic [BITS-1:0]         op_data;
  logic [1:0]              op_mask;
  logic                    op_write;
  logic [1:0][LANE_BITS-1:0] read_lanes;

  // Byte-select bit and the address bits above the RAM depth do not take part
  // in decoding, so 0x2004 aliases 0x0004 with the default depth.
  logic unused_address_bits;
  assign unused_address_bits = ^{mem_address[ADDRESS_BITS-1:DEPTH_BITS+1], mem_address[0]};

  assign request  = mem_rd | mem_wr;
  assign req_word = mem_address[DEPTH_BITS:1];

  // With LATENCY=1 the RAM access happens on the acceptance edge itself, so the
  // live bus inputs are used while IDLE; afterwards only the latched copies count.
  assign op_word  = (state_reg == IDLE) ? req_word    : word_reg;
  assign op_data  = (state_reg == IDLE) ? mem_data_in : data_reg;
  assign op_mask  = (state_reg == IDLE) ? mem_wr_mask : mask_reg;
  assign op_write = (state_reg == IDLE) ? mem_wr      : write_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    enter_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          count_next = LOAD_COUNT;
          if (LOAD_COUNT == 4'd0) begin
            state_next = DONE;
            enter_done = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          state_next = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        // The requester drops its request on this edge, so IDLE never samples here.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      count_reg      <= 4'd0;
      word_reg       <= '0;
      data_reg       <= '0;
      mask_reg       <= 2'b00;
      write_reg      <= 1'b0;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (state_reg == IDLE && request) begin
        word_reg  <= req_word;
        data_reg  <= mem_data_in;
        mask_reg  <= mem_wr_mask;
        write_reg <= mem_wr;
      end
      if (enter_done && !op_write) begin
        data_valid_reg <= 1'b1;
      end
    end
  end

  // One RAM per byte lane so each byte enable maps onto its own write strobe.
  // The read register has no reset (block-RAM friendly); data_valid_reg forces
  // the visible output to zero until the first read after reset.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [LANE_BITS-1:0] lane_mem [DEPTH];
    logic [LANE_BITS-1:0] lane_q;

    always_ff @(posedge CLK) begin
      if (!RST && enter_done) begin
        if (op_write) begin
          if (op_mask[gi]) begin
            lane_mem[op_word] <= op_data[gi*LANE_BITS +: LANE_BITS];
          end
        end else begin
          lane_q <= lane_mem[op_word];
        end
      end
    end

    assign read_lanes[gi] = lane_q;
  end

  assign mem_data_out = data_valid_reg ? read_lanes : '0;
  assign mem_success  = (state_reg == DONE);
  assign busy         = (state_reg != IDLE);

endmodule

// File: doc/slurm16_data_memory_responder.md
Name: slurm16_data_memory_responder

Overview:
- Responder end of the SLURM16 CPU data-memory bus. Sits where the CPU's memory_address/memory_rd/memory_wr/memory_wr_mask/memory_success signals terminate.
- Services byte-masked 16-bit reads and writes against an internal word-organised RAM.
- Inserts a programmable number of wait states and signals completion with a one-cycle success pulse.
- Used as the default data-memory target and as a bench model for exercising CPU stall logic.

Parameters:
- ADDRESS_BITS, 16: width of the byte address from the CPU.
- BITS, 16: data word width.
- DEPTH_BITS, 12: log2 of RAM depth in words (4096 words).
- LATENCY, 2: cycles from request acceptance to the success cycle. Legal range is 1..15.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- mem_address  in  ADDRESS_BITS  byte address. Word index = mem_address[DEPTH_BITS:1]; bit 0 and the upper bits are ignored.
- mem_data_in  in  BITS  write data from the CPU.
- mem_rd  in  1  read request, held until success is seen.
- mem_wr  in  1  write request, held until success is seen.
- mem_wr_mask  in  2  byte enables: bit0 = [7:0], bit1 = [15:8].
- mem_data_out  out  BITS  read data, registered.
- mem_success  out  1  one-cycle completion pulse.
- busy  out  1  high while in BUSY or DONE.

Behaviour:
- Reset (asynchronous, RST=1):
  - State goes to IDLE.
  - mem_success=0, mem_data_out=0, busy=0, wait counter=0.
  - RAM contents are not cleared.
- IDLE:
  - If mem_rd|mem_wr is high at a rising edge, latch the word index, data, mask and op.
  - If both mem_rd and mem_wr are high, the request is a write.
  - Load the counter with LATENCY-1. Go to DONE if that value is 0, otherwise go to BUSY.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 1 at an edge, go to DONE.
  - Request inputs are ignored in this state; the latched copies are used.
- Entering DONE (the same edge that moves the state into DONE):
  - Write: for each set mask bit, write that byte of the latched data into RAM[word]. Mask 00 writes nothing but still completes.
  - Read: mem_data_out <= RAM[word], full word; the mask is ignored.
- DONE:
  - mem_success=1 for exactly this one cycle.
  - Unconditionally return to IDLE at the next edge.
- Sampling rule: IDLE never samples on the edge that ends DONE. The requester drops or changes its request on that edge, so the held request is not re-accepted.
- Timing:
  - A request is visible in cycle 0 and mem_success is high in cycle LATENCY.
  - Minimum period between back-to-back requests is LATENCY+1 cycles.
- mem_data_out holds the last completed read. It is unchanged by writes, including a write to the same address.
- Read-after-write to the same word in consecutive transactions returns the new data; the write is committed before the IDLE cycle.
- Address wrap: word index = address[DEPTH_BITS:1]. Example with DEPTH_BITS=12: byte address 0x2004 aliases 0x0004.
- Reset mid-transaction:
  - The transaction is abandoned and no success is issued.
  - A write is committed only if the edge entering DONE already occurred.
- busy equals (state != IDLE).
- The RAM is a single synchronous port, inferable as block RAM.

Test Plan:
- Reset, then a read of 0x0000 with LATENCY=2 and RAM preloaded with 0x1234. Expect mem_success high only in cycle 2 and mem_data_out=0x1234 from cycle 2, held afterwards.
- Write 0xABCD to 0x0010 with mask 11, then read 0x0010. Expect 0xABCD. Then write 0x5566 with mask 01 and read. Expect 0xAB66. Then mask 10 with 0x7788 and read. Expect 0x7766.
- Write with mask 00 to 0x0020 holding 0x1111. Expect success is still pulsed and a read returns 0x1111.
- LATENCY=1, four back-to-back reads held until success. Expect success in cycles 1, 3, 5, 7 (period 2), no double acceptance, and busy low in cycles 2, 4 and 6.
- mem_rd and mem_wr both high, data 0x0F0F, mask 11, address 0x0002. Expect it treated as a write, mem_data_out unchanged, and a later read returns 0x0F0F. Separately, write to 0x2002 and read 0x0002. Expect the aliased value.
- LATENCY=4, write 0xBEEF issued, RST asserted in cycle 2. Expect immediate success=0, busy=0, mem_data_out=0, and a later read shows the old contents. Reset asserted in the DONE cycle leaves 0xBEEF committed.
